// File: rtl/gen_mod_sched.sv
// gen_mod_sched -- parameter scheduler for the harmonic modulation generator.
//
// Holds shadow copies of the harmonic period divider (hp) and phase. It applies
// them atomically on the generator's period-wrap trigger, so the reference
// waveforms never change mid-cycle. It also runs an hp sweep engine that steps
// hp toward a target every N generator periods.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   harmonic_trig       one-cycle pulse at each generator period wrap
//   cfg_hp/cfg_phase    requested hp / phase
//   cfg_wr, cfg_imm     write strobe; cfg_imm applies without waiting for a trigger
//   sweep_start/stop    start a sweep from the current hp / abort it
//   sweep_hp_end        final hp of the sweep
//   sweep_step          hp increment per step (unsigned magnitude)
//   sweep_dwell         generator periods per step (0 behaves as 1)
//   hp, phase           values driven to the generator
//   apply_strb          pulse in the cycle hp or phase updates
//   pending             shadow holds values not yet applied
//   sweeping            a sweep is active
//   sweep_done          pulse when the sweep reaches sweep_hp_end
//   gen_sync            (only with GEN_MOD_SCHED_RESYNC_EN) pulse with apply_strb
//                       whenever phase changes; restarts the generator counters
//
// Optional feature macro: GEN_MOD_SCHED_RESYNC_EN

module gen_mod_sched #(
  parameter int unsigned HPW = 14,
  parameter int unsigned PHW = 12,
  parameter int unsigned DWW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           harmonic_trig,
  input  logic [HPW-1:0] cfg_hp,
  input  logic [PHW-1:0] cfg_phase,
  input  logic           cfg_wr,
  input  logic           cfg_imm,
  input  logic           sweep_start,
  input  logic           sweep_stop,
  input  logic [HPW-1:0] sweep_hp_end,
  input  logic [HPW-1:0] sweep_step,
  input  logic [DWW-1:0] sweep_dwell,
  output logic [HPW-1:0] hp,
  output logic [PHW-1:0] phase,
  output logic           apply_strb,
  output logic           pending,
  output logic           sweeping,
  output logic           sweep_done
`ifdef GEN_MOD_SCHED_RESYNC_EN
  ,
  output logic           gen_sync
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [HPW-1:0] hp_q, hp_d;
  logic [PHW-1:0] phase_q, phase_d;
  logic [HPW-1:0] sh_hp_q, sh_hp_d;
  logic [PHW-1:0] sh_phase_q, sh_phase_d;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic           pending_q, pending_d;
  logic           sweeping_q, sweeping_d;
  logic           apply_q, apply_d;
  logic           done_q, done_d;

  // Dwell expiry: count after this trigger against max(sweep_dwell,1).
  // The >= compare ends a dwell promptly if sweep_dwell is lowered mid-sweep.
  logic [DWW:0] dwell_cnt, dwell_lim;
  logic         dwell_exp;

  assign dwell_cnt = {1'b0, dwell_q} + (DWW+1)'(1);
  assign dwell_lim = (sweep_dwell == '0) ? (DWW+1)'(1) : {1'b0, sweep_dwell};
  assign dwell_exp = (dwell_cnt >= dwell_lim);

  // Step toward sweep_hp_end at HPW+1 bits; clamp on overshoot or underflow.
  logic [HPW:0]   hp_w, end_w, step_w, up_sum, dn_diff;
  logic [HPW-1:0] hp_step;

  assign hp_w    = {1'b0, hp_q};
  assign end_w   = {1'b0, sweep_hp_end};
  assign step_w  = {1'b0, sweep_step};
  assign up_sum  = hp_w + step_w;
  assign dn_diff = hp_w - step_w;

  always_comb begin
    hp_step = sweep_hp_end;
    if (end_w > hp_w) begin
      if (up_sum <= end_w) hp_step = up_sum[HPW-1:0];
    end else begin
      if ((step_w <= hp_w) && (dn_diff >= end_w)) hp_step = dn_diff[HPW-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    phase_d    = phase_q;
    sh_hp_d    = sh_hp_q;
    sh_phase_d = sh_phase_q;
    dwell_d    = dwell_q;
    pending_d  = pending_q;
    sweeping_d = sweeping_q;
    apply_d    = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_wr) begin
          if (cfg_imm) begin
            hp_d    = cfg_hp;
            phase_d = cfg_phase;
            apply_d = 1'b1;
          end else begin
            sh_hp_d    = cfg_hp;
            sh_phase_d = cfg_phase;
            pending_d  = 1'b1;
            state_d    = PEND;
          end
        end else if (sweep_start) begin
          dwell_d    = '0;
          sweeping_d = 1'b1;
          state_d    = SWEEP;
        end
      end

      PEND: begin
        if (cfg_wr && (cfg_imm || harmonic_trig)) begin
          // A write coinciding with the trigger bypasses the shadow.
          hp_d      = cfg_hp;
          phase_d   = cfg_phase;
          apply_d   = 1'b1;
          pending_d = 1'b0;
          state_d   = IDLE;
        end else if (cfg_wr) begin
          sh_hp_d    = cfg_hp;
          sh_phase_d = cfg_phase;
        end else if (harmonic_trig) begin
          hp_d      = sh_hp_q;
          phase_d   = sh_phase_q;
          apply_d   = 1'b1;
          pending_d = 1'b0;
          state_d   = IDLE;
        end
      end

      SWEEP: begin
        if (cfg_wr) begin
          sh_hp_d    = cfg_hp;
          sh_phase_d = cfg_phase;
          pending_d  = 1'b1;
        end
        if (sweep_stop) begin
          sweeping_d = 1'b0;
          state_d    = pending_d ? PEND : IDLE;
        end else if (harmonic_trig) begin
          if (dwell_exp) begin
            dwell_d = '0;
            // A zero step can never reach the end; finish instead of hanging.
            if ((hp_q == sweep_hp_end) || (sweep_step == '0)) begin
              done_d     = 1'b1;
              sweeping_d = 1'b0;
              state_d    = pending_d ? PEND : IDLE;
            end else begin
              hp_d    = hp_step;
              apply_d = 1'b1;
            end
          end else begin
            dwell_d = dwell_cnt[DWW-1:0];
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hp_q       <= '0;
      phase_q    <= '0;
      sh_hp_q    <= '0;
      sh_phase_q <= '0;
      dwell_q    <= '0;
      pending_q  <= 1'b0;
      sweeping_q <= 1'b0;
      apply_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      phase_q    <= phase_d;
      sh_hp_q    <= sh_hp_d;
      sh_phase_q <= sh_phase_d;
      dwell_q    <= dwell_d;
      pending_q  <= pending_d;
      sweeping_q <= sweeping_d;
      apply_q    <= apply_d;
      done_q     <= done_d;
    end
  end

  assign hp         = hp_q;
  assign phase      = phase_q;
  assign apply_strb = apply_q;
  assign pending    = pending_q;
  assign sweeping   = sweeping_q;
  assign sweep_done = done_q;

`ifdef GEN_MOD_SCHED_RESYNC_EN
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= apply_d && (phase_d != phase_q);
    end
  end

  assign gen_sync = sync_q;
`endif

endmodule

// File: tb/tb_gen_mod_sched.sv
module tb_gen_mod_sched;

  logic        clk;
  logic        rst;
  logic        harmonic_trig;
  logic [13:0] cfg_hp;
  logic [11:0] cfg_phase;
  logic        cfg_wr;
  logic        cfg_imm;
  logic        sweep_start;
  logic        sweep_stop;
  logic [13:0] sweep_hp_end;
  logic [13:0] sweep_step;
  logic [15:0] sweep_dwell;
  logic [13:0] hp;
  logic [11:0] phase;
  logic        apply_strb;
  logic        pending;
  logic        sweeping;
  logic        sweep_done;
`ifdef GEN_MOD_SCHED_RESYNC_EN
  logic        gen_sync;
`endif

  int checks = 0;
  int errors = 0;

  gen_mod_sched #(.HPW(14), .PHW(12), .DWW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .harmonic_trig(harmonic_trig),
    .cfg_hp       (cfg_hp),
    .cfg_phase    (cfg_phase),
    .cfg_wr       (cfg_wr),
    .cfg_imm      (cfg_imm),
    .sweep_start  (sweep_start),
    .sweep_stop   (sweep_stop),
    .sweep_hp_end (sweep_hp_end),
    .sweep_step   (sweep_step),
    .sweep_dwell  (sweep_dwell),
    .hp           (hp),
    .phase        (phase),
    .apply_strb   (apply_strb),
    .pending      (pending),
    .sweeping     (sweeping),
    .sweep_done   (sweep_done)
`ifdef GEN_MOD_SCHED_RESYNC_EN
    ,
    .gen_sync     (gen_sync)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Output vector order: {hp, phase, apply_strb, pending, sweeping, sweep_done}
  task automatic test_reset();
    rst = 1'b0; harmonic_trig = 1'b0; cfg_hp = '0; cfg_phase = '0;
    cfg_wr = 1'b0; cfg_imm = 1'b0; sweep_start = 1'b0; sweep_stop = 1'b0;
    sweep_hp_end = '0; sweep_step = '0; sweep_dwell = '0;
    #12;
    checks++;
    if ({hp, phase, apply_strb, pending, sweeping, sweep_done} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h",
               {hp, phase, apply_strb, pending, sweeping, sweep_done}, 30'd0);
    end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_pending();
    bit held = 1'b1;
    cfg_hp = 14'd9; cfg_phase = 12'd630; cfg_imm = 1'b0; cfg_wr = 1'b1;
    cyc();
    cfg_wr = 1'b0;
    checks++;
    if ({hp, phase, apply_strb, pending} !== {14'd0, 12'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL pend_latch: got %h want %h", {hp, phase, apply_strb, pending},
               {14'd0, 12'd0, 1'b0, 1'b1});
    end
    for (int i = 0; i < 19; i++) begin
      cyc();
      if (pending !== 1'b1 || apply_strb !== 1'b0 || hp !== 14'd0) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL pend_hold: got %0b want 1", held);
    end
    harmonic_trig = 1'b1;
    cyc();
    harmonic_trig = 1'b0;
    checks++;
    if ({hp, phase, apply_strb, pending} !== {14'd9, 12'd630, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pend_apply: got %h want %h", {hp, phase, apply_strb, pending},
               {14'd9, 12'd630, 1'b1, 1'b0});
    end
`ifdef GEN_MOD_SCHED_RESYNC_EN
    checks++;
    if (gen_sync !== 1'b1) begin
      errors++;
      $display("FAIL pend_sync: got %0b want 1", gen_sync);
    end
`endif
    cyc();
    checks++;
    if (apply_strb !== 1'b0) begin
      errors++;
      $display("FAIL pend_strb_single: got %0b want 0", apply_strb);
    end
  endtask

  task automatic test_immediate();
    cfg_hp = 14'd4; cfg_phase = 12'd630; cfg_imm = 1'b1; cfg_wr = 1'b1;
    cyc();
    cfg_wr = 1'b0; cfg_imm = 1'b0;
    checks++;
    if ({hp, phase, apply_strb, pending} !== {14'd4, 12'd630, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL imm_apply: got %h want %h", {hp, phase, apply_strb, pending},
               {14'd4, 12'd630, 1'b1, 1'b0});
    end
`ifdef GEN_MOD_SCHED_RESYNC_EN
    checks++;
    if (gen_sync !== 1'b0) begin
      errors++;
      $display("FAIL imm_no_sync: got %0b want 0", gen_sync);
    end
`endif
    cyc();
    checks++;
    if (apply_strb !== 1'b0) begin
      errors++;
      $display("FAIL imm_strb_single: got %0b want 0", apply_strb);
    end
  endtask

  task automatic test_sweep_up();
    logic [13:0] exp_hp [8];
    logic        exp_ap [8];
    exp_hp = '{14'd0, 14'd4, 14'd4, 14'd8, 14'd8, 14'd10, 14'd10, 14'd10};
    exp_ap = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    // bring hp to 0 first
    cfg_hp = 14'd0; cfg_phase = 12'd630; cfg_imm = 1'b1; cfg_wr = 1'b1;
    cyc();
    cfg_wr = 1'b0; cfg_imm = 1'b0;
    sweep_hp_end = 14'd10; sweep_step = 14'd4; sweep_dwell = 16'd2;
    sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    checks++;
    if ({hp, sweeping, sweep_done} !== {14'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sweep_start: got %h want %h", {hp, sweeping, sweep_done},
               {14'd0, 1'b1, 1'b0});
    end
    for (int k = 0; k < 8; k++) begin
      harmonic_trig = 1'b1;
      cyc();
      harmonic_trig = 1'b0;
      checks++;
      if ({hp, apply_strb, sweeping, sweep_done} !==
          {exp_hp[k], exp_ap[k], (k != 7), (k == 7)}) begin
        errors++;
        $display("FAIL sweep_trig%0d: got %h want %h", k + 1,
                 {hp, apply_strb, sweeping, sweep_done},
                 {exp_hp[k], exp_ap[k], (k != 7), (k == 7)});
      end
      cyc();
      cyc();
    end
    checks++;
    if ({sweep_done, sweeping, phase} !== {1'b0, 1'b0, 12'd630}) begin
      errors++;
      $display("FAIL sweep_after: got %h want %h", {sweep_done, sweeping, phase},
               {1'b0, 1'b0, 12'd630});
    end
  endtask

  task automatic test_pend_collide();
    cfg_hp = 14'd5; cfg_phase = 12'd630; cfg_imm = 1'b0; cfg_wr = 1'b1;
    cyc();
    checks++;
    if ({hp, pending} !== {14'd10, 1'b1}) begin
      errors++;
      $display("FAIL collide_pend: got %h want %h", {hp, pending}, {14'd10, 1'b1});
    end
    cfg_hp = 14'd7; harmonic_trig = 1'b1;
    cyc();
    cfg_wr = 1'b0; harmonic_trig = 1'b0;
    checks++;
    if ({hp, apply_strb, pending} !== {14'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL collide_apply: got %h want %h", {hp, apply_strb, pending},
               {14'd7, 1'b1, 1'b0});
    end
    // Only IDLE accepts sweep_start, so this proves the return to IDLE.
    sweep_hp_end = 14'd7; sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    checks++;
    if (sweeping !== 1'b1) begin
      errors++;
      $display("FAIL collide_idle: got %0b want 1", sweeping);
    end
    sweep_stop = 1'b1;
    cyc();
    sweep_stop = 1'b0;
    checks++;
    if ({sweeping, sweep_done, hp} !== {1'b0, 1'b0, 14'd7}) begin
      errors++;
      $display("FAIL collide_stop: got %h want %h", {sweeping, sweep_done, hp},
               {1'b0, 1'b0, 14'd7});
    end
  endtask

  task automatic test_sweep_stop();
    sweep_hp_end = 14'd20; sweep_step = 14'd5; sweep_dwell = 16'd1;
    sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    harmonic_trig = 1'b1;
    cyc();
    harmonic_trig = 1'b0;
    checks++;
    if ({hp, apply_strb, sweeping} !== {14'd12, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL stop_step: got %h want %h", {hp, apply_strb, sweeping},
               {14'd12, 1'b1, 1'b1});
    end
    // cfg_imm must be ignored while sweeping
    cfg_hp = 14'd3; cfg_phase = 12'd100; cfg_imm = 1'b1; cfg_wr = 1'b1;
    cyc();
    cfg_wr = 1'b0; cfg_imm = 1'b0;
    checks++;
    if ({hp, phase, apply_strb, pending, sweeping} !==
        {14'd12, 12'd630, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL stop_shadow: got %h want %h", {hp, phase, apply_strb, pending, sweeping},
               {14'd12, 12'd630, 1'b0, 1'b1, 1'b1});
    end
    // stop beats a coincident step
    sweep_stop = 1'b1; harmonic_trig = 1'b1;
    cyc();
    sweep_stop = 1'b0; harmonic_trig = 1'b0;
    checks++;
    if ({hp, apply_strb, pending, sweeping, sweep_done} !==
        {14'd12, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stop_exit: got %h want %h", {hp, apply_strb, pending, sweeping, sweep_done},
               {14'd12, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    harmonic_trig = 1'b1;
    cyc();
    harmonic_trig = 1'b0;
    checks++;
    if ({hp, phase, apply_strb, pending} !== {14'd3, 12'd100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stop_apply: got %h want %h", {hp, phase, apply_strb, pending},
               {14'd3, 12'd100, 1'b1, 1'b0});
    end
`ifdef GEN_MOD_SCHED_RESYNC_EN
    checks++;
    if (gen_sync !== 1'b1) begin
      errors++;
      $display("FAIL stop_sync: got %0b want 1", gen_sync);
    end
`endif
  endtask

  task automatic test_zero_step();
    sweep_hp_end = 14'd9; sweep_step = 14'd0; sweep_dwell = 16'd0;
    sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    harmonic_trig = 1'b1;
    cyc();
    harmonic_trig = 1'b0;
    checks++;
    if ({hp, apply_strb, sweeping, sweep_done} !== {14'd3, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL zero_step: got %h want %h", {hp, apply_strb, sweeping, sweep_done},
               {14'd3, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_sweep_down();
    logic [13:0] exp_hp [3];
    exp_hp = '{14'd6, 14'd2, 14'd1};
    cfg_hp = 14'd10; cfg_phase = 12'd100; cfg_imm = 1'b1; cfg_wr = 1'b1;
    cyc();
    cfg_wr = 1'b0; cfg_imm = 1'b0;
    sweep_hp_end = 14'd1; sweep_step = 14'd4; sweep_dwell = 16'd1;
    sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      harmonic_trig = 1'b1;
      cyc();
      harmonic_trig = 1'b0;
      checks++;
      if ({hp, apply_strb, sweeping} !== {exp_hp[k], 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL down_step%0d: got %h want %h", k, {hp, apply_strb, sweeping},
                 {exp_hp[k], 1'b1, 1'b1});
      end
    end
    harmonic_trig = 1'b1;
    cyc();
    harmonic_trig = 1'b0;
    checks++;
    if ({hp, sweeping, sweep_done} !== {14'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL down_done: got %h want %h", {hp, sweeping, sweep_done},
               {14'd1, 1'b0, 1'b1});
    end
  endtask

  task automatic test_reset_mid();
    sweep_hp_end = 14'd9; sweep_step = 14'd2; sweep_dwell = 16'd1;
    sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    harmonic_trig = 1'b1;
    cyc();
    harmonic_trig = 1'b0;
    cfg_hp = 14'd8; cfg_phase = 12'd200; cfg_wr = 1'b1;
    cyc();
    cfg_wr = 1'b0;
    checks++;
    if ({hp, pending, sweeping} !== {14'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rmid_pre: got %h want %h", {hp, pending, sweeping},
               {14'd3, 1'b1, 1'b1});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({hp, phase, apply_strb, pending, sweeping, sweep_done} !== 30'd0) begin
      errors++;
      $display("FAIL rmid_async: got %h want %h",
               {hp, phase, apply_strb, pending, sweeping, sweep_done}, 30'd0);
    end
    cyc();
    rst = 1'b1;
    cyc();
    harmonic_trig = 1'b1;
    cyc();
    harmonic_trig = 1'b0;
    checks++;
    if ({hp, phase, apply_strb, pending, sweeping} !== {14'd0, 12'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rmid_lost: got %h want %h", {hp, phase, apply_strb, pending, sweeping},
               {14'd0, 12'd0, 1'b0, 1'b0, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_pending();
    test_immediate();
    test_sweep_up();
    test_pend_collide();
    test_sweep_stop();
    test_zero_step();
    test_sweep_down();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gen_mod_sched.md
Name: gen_mod_sched

Overview:
- Parameter scheduler for the harmonic modulation generator.
- Holds shadow copies of the harmonic period divider (hp) and the phase setting.
- Applies new values atomically on the generator's period-boundary trigger, so the reference waveforms never change mid-cycle.
- Provides an hp sweep engine that steps the modulation frequency every N generator periods. Sits between the register bank and the generator.

Parameters:
- HPW, 14, width of hp.
- PHW, 12, width of phase (2520-step period).
- DWW, 16, width of the dwell counter (generator periods per sweep step).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- harmonic_trig  in  1  one-cycle pulse from the generator at each period wrap.
- cfg_hp  in  HPW  requested hp.
- cfg_phase  in  PHW  requested phase.
- cfg_wr  in  1  strobe; latches cfg_hp and cfg_phase into the shadow.
- cfg_imm  in  1  sampled with cfg_wr; apply without waiting for a trigger.
- sweep_start  in  1  strobe; start a sweep from the current hp.
- sweep_stop  in  1  strobe; abort the sweep.
- sweep_hp_end  in  HPW  final hp of the sweep.
- sweep_step  in  HPW  hp increment per step, unsigned magnitude.
- sweep_dwell  in  DWW  generator periods per step; 0 is treated as 1.
- hp  out  HPW  hp driven to the generator.
- phase  out  PHW  phase driven to the generator.
- apply_strb  out  1  one-cycle pulse in the cycle hp or phase updates.
- pending  out  1  the shadow holds values not yet applied.
- sweeping  out  1  a sweep is active.
- sweep_done  out  1  one-cycle pulse when the sweep reaches sweep_hp_end.

Behaviour:
- Reset: all outputs 0, shadow registers 0, dwell counter 0, state IDLE.
- All outputs are registered. Latency is one clock from the triggering input edge to the output change.
- States are IDLE, PEND and SWEEP.
- IDLE:
  - cfg_wr with cfg_imm=1: hp and phase load cfg_* at the next edge, apply_strb=1, stay IDLE.
  - cfg_wr with cfg_imm=0: shadow loads, pending=1, go to PEND.
  - sweep_start (with no cfg_wr): dwell counter cleared, sweeping=1, go to SWEEP.
  - cfg_wr and sweep_start in the same cycle: cfg_wr wins and sweep_start is dropped.
- PEND:
  - cfg_wr overwrites the shadow and the state stays PEND. cfg_imm=1 here applies immediately and returns to IDLE.
  - harmonic_trig: hp and phase load the shadow, apply_strb=1, pending=0, go to IDLE.
  - cfg_wr and harmonic_trig in the same cycle: the new cfg_* values (bypassing the shadow) are applied.
  - sweep_start is ignored.
- SWEEP:
  - Each harmonic_trig increments the dwell counter.
  - When the count reaches max(sweep_dwell,1) on a trigger, the counter clears and hp steps toward sweep_hp_end.
  - Step arithmetic is done at HPW+1 bits and clamped so hp never passes sweep_hp_end.
  - On a step, apply_strb=1. phase is unchanged during a sweep.
  - If hp already equals sweep_hp_end at dwell expiry: sweep_done=1, sweeping=0, go to PEND if pending else IDLE.
  - sweep_step=0 with hp≠sweep_hp_end: the sweep finishes with sweep_done at the first dwell expiry and hp is unchanged. This prevents a hang.
  - sweep_stop: sweeping=0 at the next edge, hp holds, no sweep_done. Exit goes to PEND if pending, else IDLE. sweep_stop takes priority over a coincident step.
  - cfg_wr: shadow loads and pending=1. It is not applied until the sweep exits; cfg_imm is ignored.
  - sweep_end and cfg fields are sampled live. Changing them mid-sweep takes effect at the next step.
- Reset asserted mid-sweep or mid-PEND: immediate return to the reset values; pending updates are lost.

Optional Feature:
- Macro: GEN_MOD_SCHED_RESYNC_EN.
- When defined: adds an output port gen_sync (1 bit), asserted for exactly one cycle coincident with apply_strb whenever phase changes. It restarts the generator counters so the new phase takes effect from a clean cycle. Reset value 0.
- When undefined: the port is absent and no resync pulse is generated.

Test Plan:
- cfg_wr with cfg_hp=9, cfg_phase=630, cfg_imm=0; harmonic_trig 20 cycles later -> pending=1 for 20 cycles; hp=9 and phase=630 one cycle after the trigger with a single apply_strb; pending=0.
- cfg_wr with cfg_imm=1, cfg_hp=4 -> hp=4 on the next edge, apply_strb once, no trigger needed.
- Sweep from hp=0 with sweep_hp_end=10, sweep_step=4, sweep_dwell=2 and periodic triggers -> hp sequence 4, 8, 10 every 2nd trigger; sweep_done one trigger-dwell after hp reaches 10; sweeping=0.
- In PEND, cfg_wr with cfg_hp=7 in the same cycle as harmonic_trig -> hp=7 applied directly; state IDLE.
- During a sweep: cfg_wr with cfg_hp=3, then sweep_stop -> hp holds its last step value, no sweep_done, pending=1; the next harmonic_trig applies hp=3.
- sweep_step=0 with sweep_hp_end≠hp, and sweep_dwell=0 -> sweep_done on the first trigger, hp unchanged. A rst pulse mid-sweep -> all outputs 0 immediately.
